// File: rtl/pp_n3_pkg.sv
// Shared definitions for the N3 GTP-U header parser.
// Holds the packet-header-summary (PHS) layout, protocol constants and the
// capture FSM state type.
package pp_n3_pkg;

  localparam int PHS_W = 120;

  // PHS bit positions (LSB of each field)
  localparam int PHS_SRC_IP_LSB   = 88;
  localparam int PHS_DST_IP_LSB   = 56;
  localparam int PHS_PROTO_LSB    = 48;
  localparam int PHS_SPORT_LSB    = 32;
  localparam int PHS_DPORT_LSB    = 16;
  localparam int PHS_QFI_LSB      = 10;
  localparam int PHS_PDU_TYPE_LSB = 6;
  localparam int PHS_VALID_BIT    = 5;
  localparam int PHS_TCP_BIT      = 4;
  localparam int PHS_UDP_BIT      = 3;
  localparam int PHS_PDU_BIT      = 2;
  localparam int PHS_OUTER_BIT    = 1;
  localparam int PHS_GTP_BIT      = 0;

  localparam logic [15:0] ETH_IPV4     = 16'h0800;
  localparam logic [15:0] GTPU_PORT    = 16'd2152;
  localparam logic [7:0]  GTP_GPDU     = 8'hFF;
  localparam logic [7:0]  EXT_PDU_SESS = 8'h85;
  localparam logic [7:0]  IP_PROTO_TCP = 8'd6;
  localparam logic [7:0]  IP_PROTO_UDP = 8'd17;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  proto;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [5:0]  qfi;
    logic [3:0]  pdu_type;
    logic        phs_valid;
    logic        inner_is_tcp;
    logic        inner_is_udp;
    logic        pdu_present;
    logic        outer_ok;
    logic        gtp_ok;
  } phs_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_PARSE} cap_state_e;

endpackage

// File: rtl/pp_hdr_capture.sv
// Header capture: collects the first HDR_BYTES of each packet into a buffer,
// then hands a stable snapshot to the parser with a one-cycle parse strobe.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_bus          : beat, first byte at MSBs
//   i_sop          : first beat of a packet
//   o_hdr          : snapshot, byte n at o_hdr[HDR_BYTES-1-n]
//   o_parse        : high for the one cycle the snapshot must be parsed
module pp_hdr_capture
  import pp_n3_pkg::*;
#(
  parameter int BUS_WIDTH_B = 16,
  parameter int BYTE_WIDTH  = 8,
  parameter int HDR_BYTES   = 192
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [BUS_WIDTH_B*BYTE_WIDTH-1:0]     i_bus,
  input  logic                                  i_sop,
  output logic [HDR_BYTES-1:0][BYTE_WIDTH-1:0]  o_hdr,
  output logic                                  o_parse
);
  localparam int HDR_BEATS = HDR_BYTES / BUS_WIDTH_B;
  localparam int BEAT_W    = BUS_WIDTH_B * BYTE_WIDTH;
  localparam int CNT_W     = $clog2(HDR_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HDR_BEATS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HDR_BEATS);

  // Beat 0 sits at the top index so the flattened buffer reads first byte at MSB.
  logic [HDR_BEATS-1:0][BEAT_W-1:0] r_buf, r_pbuf, w_buf_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fresh;   // a packet is being captured and not yet handed over
  cap_state_e       r_state;
  logic             w_wr, w_early, w_last;

  assign w_wr    = !i_sop && (r_cnt != '0) && (r_cnt < FULL_CNT);
  assign w_early = i_sop && r_fresh;
  assign w_last  = w_wr && r_fresh && (r_cnt == LAST_CNT);

  always_comb begin
    w_buf_nxt = r_buf;
    if (i_sop) begin
      w_buf_nxt = '0;
      w_buf_nxt[HDR_BEATS-1] = i_bus;
    end else if (w_wr) begin
      w_buf_nxt[LAST_CNT - r_cnt] = i_bus;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf   <= '0;
      r_pbuf  <= '0;
      r_cnt   <= '0;
      r_fresh <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_buf <= w_buf_nxt;
      if (i_sop)     r_cnt <= CNT_W'(1);
      else if (w_wr) r_cnt <= r_cnt + 1'b1;
      if (i_sop)       r_fresh <= 1'b1;
      else if (w_last) r_fresh <= 1'b0;
      // Early sop parses the old packet as-is; a full window includes this beat.
      if (w_early)     r_pbuf <= r_buf;
      else if (w_last) r_pbuf <= w_buf_nxt;
      if (w_early || w_last)  r_state <= ST_PARSE;
      else if (i_sop || r_fresh) r_state <= ST_CAPTURE;
      else                    r_state <= ST_IDLE;
    end
  end

  assign o_hdr   = r_pbuf;
  assign o_parse = (r_state == ST_PARSE);

endmodule

// File: rtl/pp_n3_gtpu_parser.sv
// N3 user-plane header parser: Eth / IPv4 / UDP 2152 / GTP-U [/ PDU session
// container] / inner IPv4 / TCP|UDP. Produces a registered 120-bit summary.
// Ports:
//   CLK, reset        : clock, async active-low reset
//   bus               : packet beat, first byte at MSBs
//   start_of_packet_i : first beat of a packet
//   phs_o             : packet header summary, held until the next packet
module pp_n3_gtpu_parser
  import pp_n3_pkg::*;
#(
  parameter int BUS_WIDTH_B = 16,
  parameter int BYTE_WIDTH  = 8,
  parameter int HDR_BYTES   = 192
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic [BUS_WIDTH_B*BYTE_WIDTH-1:0] bus,
  input  logic                              start_of_packet_i,
  output logic [PHS_W-1:0]                  phs_o
);
  localparam int          AW   = $clog2(HDR_BYTES);
  localparam logic [31:0] HB_U = 32'(HDR_BYTES);

  logic [HDR_BYTES-1:0][BYTE_WIDTH-1:0] w_hdr;
  logic             w_parse;
  phs_t             w_s;
  logic [PHS_W-1:0] w_phs, r_phs;

  logic [7:0]  w_vo, w_gf, w_clen, w_ivh, w_iproto, w_qb, w_pb;
  logic [31:0] w_u, w_g, w_i, w_l;
  logic        w_outer_ok, w_gtp_ok, w_cont, w_cont_err, w_in_ok, w_l4, w_l4_fit;

  pp_hdr_capture #(
    .BUS_WIDTH_B(BUS_WIDTH_B), .BYTE_WIDTH(BYTE_WIDTH), .HDR_BYTES(HDR_BYTES)
  ) u_cap (
    .i_clk(CLK), .i_rst_n(reset), .i_bus(bus), .i_sop(start_of_packet_i),
    .o_hdr(w_hdr), .o_parse(w_parse)
  );

  // Bytes past the capture window read as zero.
  function automatic logic [BYTE_WIDTH-1:0] byte_at(
    input logic [HDR_BYTES-1:0][BYTE_WIDTH-1:0] h, input logic [31:0] p);
    logic [AW-1:0] idx;
    idx = AW'(HB_U - 32'd1 - p);
    byte_at = (p < HB_U) ? h[idx] : '0;
  endfunction

  always_comb begin
    w_vo       = byte_at(w_hdr, 32'd14);
    w_u        = 32'd14 + {26'd0, w_vo[3:0], 2'b00};
    w_outer_ok = ({byte_at(w_hdr, 32'd12), byte_at(w_hdr, 32'd13)} == ETH_IPV4) &&
                 (w_vo[7:4] == 4'd4) && (w_vo[3:0] >= 4'd5) &&
                 (byte_at(w_hdr, 32'd23) == IP_PROTO_UDP) &&
                 ({byte_at(w_hdr, w_u + 32'd2), byte_at(w_hdr, w_u + 32'd3)} == GTPU_PORT);
    w_g        = w_u + 32'd8;
    w_gf       = byte_at(w_hdr, w_g);
    // GTP bytes are only meaningful once the outer walk has located them.
    w_gtp_ok   = w_outer_ok && (w_gf[7:5] == 3'd1) && w_gf[4] &&
                 (byte_at(w_hdr, w_g + 32'd1) == GTP_GPDU);
    w_cont     = w_gtp_ok && w_gf[2] && (byte_at(w_hdr, w_g + 32'd11) == EXT_PDU_SESS);
    w_clen     = byte_at(w_hdr, w_g + 32'd12);
    w_cont_err = w_cont && (w_clen == 8'd0);
    w_qb       = byte_at(w_hdr, w_g + 32'd14);
    w_pb       = byte_at(w_hdr, w_g + 32'd13);
    w_i        = w_cont ? (w_g + 32'd12 + {22'd0, w_clen, 2'b00})
                        : (w_g + ((|w_gf[2:0]) ? 32'd12 : 32'd8));
    w_ivh      = byte_at(w_hdr, w_i);
    w_iproto   = byte_at(w_hdr, w_i + 32'd9);
    w_in_ok    = w_gtp_ok && !w_cont_err && (w_i + 32'd20 <= HB_U) &&
                 (w_ivh[7:4] == 4'd4) && (w_ivh[3:0] >= 4'd5);
    w_l        = w_i + {26'd0, w_ivh[3:0], 2'b00};
    w_l4       = w_in_ok && ((w_iproto == IP_PROTO_TCP) || (w_iproto == IP_PROTO_UDP));
    w_l4_fit   = (w_l + 32'd4 <= HB_U);

    w_s = '0;
    w_s.outer_ok    = w_outer_ok;
    w_s.gtp_ok      = w_gtp_ok;
    w_s.pdu_present = w_cont;
    if (w_cont) begin
      w_s.qfi      = w_qb[5:0];
      w_s.pdu_type = w_pb[7:4];
    end
    if (w_in_ok) begin
      w_s.src_ip = {byte_at(w_hdr, w_i + 32'd12), byte_at(w_hdr, w_i + 32'd13),
                    byte_at(w_hdr, w_i + 32'd14), byte_at(w_hdr, w_i + 32'd15)};
      w_s.dst_ip = {byte_at(w_hdr, w_i + 32'd16), byte_at(w_hdr, w_i + 32'd17),
                    byte_at(w_hdr, w_i + 32'd18), byte_at(w_hdr, w_i + 32'd19)};
      w_s.proto        = w_iproto;
      w_s.inner_is_tcp = (w_iproto == IP_PROTO_TCP);
      w_s.inner_is_udp = (w_iproto == IP_PROTO_UDP);
    end
    if (w_l4 && w_l4_fit) begin
      w_s.src_port = {byte_at(w_hdr, w_l), byte_at(w_hdr, w_l + 32'd1)};
      w_s.dst_port = {byte_at(w_hdr, w_l + 32'd2), byte_at(w_hdr, w_l + 32'd3)};
    end
    // A truncated L4 header invalidates the summary; non-L4 protocols do not.
    w_s.phs_valid = w_in_ok && (!w_l4 || w_l4_fit);
  end

  always_comb begin
    w_phs = '0;
    w_phs[PHS_SRC_IP_LSB +: 32]  = w_s.src_ip;
    w_phs[PHS_DST_IP_LSB +: 32]  = w_s.dst_ip;
    w_phs[PHS_PROTO_LSB +: 8]    = w_s.proto;
    w_phs[PHS_SPORT_LSB +: 16]   = w_s.src_port;
    w_phs[PHS_DPORT_LSB +: 16]   = w_s.dst_port;
    w_phs[PHS_QFI_LSB +: 6]      = w_s.qfi;
    w_phs[PHS_PDU_TYPE_LSB +: 4] = w_s.pdu_type;
    w_phs[PHS_VALID_BIT]         = w_s.phs_valid;
    w_phs[PHS_TCP_BIT]           = w_s.inner_is_tcp;
    w_phs[PHS_UDP_BIT]           = w_s.inner_is_udp;
    w_phs[PHS_PDU_BIT]           = w_s.pdu_present;
    w_phs[PHS_OUTER_BIT]         = w_s.outer_ok;
    w_phs[PHS_GTP_BIT]           = w_s.gtp_ok;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)       r_phs <= '0;
    else if (w_parse) r_phs <= w_phs;
  end

  assign phs_o = r_phs;

endmodule

// File: tb/tb_pp_n3_gtpu_parser.sv
// Scoreboard bench for pp_n3_gtpu_parser: stimulus queues the expected PHS
// with the cycle it must appear; a monitor checks phs_o every cycle.
module tb_pp_n3_gtpu_parser;
  logic         clk, rst_n, sop;
  logic [127:0] bus;
  logic [119:0] phs;

  pp_n3_gtpu_parser dut (
    .CLK(clk), .reset(rst_n), .bus(bus), .start_of_packet_i(sop), .phs_o(phs)
  );

  typedef struct { int due; logic [119:0] phs; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;
  logic [7:0]   pkt [192];
  logic [119:0] pend;
  bit           pend_v = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Monitor: phs_o must equal the latest due expectation on every cycle.
  initial begin
    logic [119:0] cur;
    cur = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) cur = '0;
      else if (q.size() > 0 && q[0].due == cyc) cur = q.pop_front().phs;
      total++;
      if (phs !== cur) begin
        bad++;
        $display("FAIL phs cyc=%0d got=%h exp=%h", cyc, phs, cur);
      end
    end
  end

  function automatic logic [119:0] mkphs(input logic [31:0] s, d, input logic [7:0] p,
    input logic [15:0] sp, dp, input logic [5:0] qf, input logic [3:0] t, input logic [5:0] f);
    return {s, d, p, sp, dp, qf, t, f};  // f = {valid,tcp,udp,pdu,outer,gtp}
  endfunction

  task automatic setb(input int idx, input logic [7:0] v);
    if (idx < 192) pkt[idx] = v;
  endtask

  task automatic build(input int ihl_o, input logic [15:0] dport, input logic [2:0] gfl,
    input logic [7:0] ext, input int clen, input logic [3:0] pt, input logic [5:0] qfi,
    input int iihl, input logic [7:0] proto, input logic [31:0] src, dst,
    input logic [15:0] sp, dp);
    int u, g, ii, l;
    for (int i = 0; i < 192; i++) pkt[i] = 8'h00;
    for (int i = 0; i < 12; i++) setb(i, 8'(8'h10 + i));
    setb(12, 8'h08); setb(13, 8'h00);
    setb(14, {4'h4, 4'(ihl_o)}); setb(23, 8'd17);
    u = 14 + 4 * ihl_o;
    for (int i = 34; i < u; i++) setb(i, 8'hCD);
    setb(u, 8'h08); setb(u + 1, 8'h68); setb(u + 2, dport[15:8]); setb(u + 3, dport[7:0]);
    g = u + 8;
    setb(g, {3'b001, 1'b1, 1'b0, gfl}); setb(g + 1, 8'hFF);
    if (|gfl) setb(g + 11, ext);
    if (gfl[2] && ext == 8'h85) begin
      setb(g + 12, 8'(clen)); setb(g + 13, {pt, 4'h0}); setb(g + 14, {2'b00, qfi});
      ii = g + 12 + 4 * ((clen == 0) ? 1 : clen);
    end else begin
      ii = g + ((|gfl) ? 12 : 8);
    end
    setb(ii, {4'h4, 4'(iihl)}); setb(ii + 9, proto);
    for (int k = 0; k < 4; k++) begin
      setb(ii + 12 + k, src[31-8*k -: 8]);
      setb(ii + 16 + k, dst[31-8*k -: 8]);
    end
    l = ii + 4 * iihl;
    for (int i = ii + 20; i < l; i++) setb(i, 8'hAB);
    setb(l, sp[15:8]); setb(l + 1, sp[7:0]); setb(l + 2, dp[15:8]); setb(l + 3, dp[7:0]);
  endtask

  // n beats of pkt; a full window is due 2 cycles after its last beat is driven,
  // a short one 2 cycles after the next sop is driven.
  task automatic send_pkt(input int n, input logic [119:0] e, input bit chk);
    for (int b = 0; b < n; b++) begin
      @(posedge clk); #1;
      if (b == 0 && pend_v) begin q.push_back('{cyc + 2, pend}); pend_v = 0; end
      sop = (b == 0);
      for (int j = 0; j < 16; j++) bus[(15-j)*8 +: 8] = pkt[b*16 + j];
      if (chk && n == 12 && b == 11) q.push_back('{cyc + 2, e});
    end
    if (chk && n < 12) begin pend = e; pend_v = 1; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; sop = 0; bus = '0; end
  endtask

  localparam logic [31:0] A1 = 32'h0A000001, A2 = 32'h0A000002;

  initial begin
    rst_n = 0; sop = 0; bus = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(5);
    // T1: container len1 QFI9, inner UDP 1234->80
    build(5, 16'd2152, 3'b100, 8'h85, 1, 4'd0, 6'd9, 5, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, mkphs(A1, A2, 8'h11, 16'h04D2, 16'h0050, 6'd9, 4'd0, 6'b101111), 1);
    // T2: inner IHL 7, TCP; sop lands in T1's parse cycle
    build(5, 16'd2152, 3'b100, 8'h85, 1, 4'd0, 6'd9, 7, 8'd6, 32'hC0A80001, 32'hC0A80002, 16'h1F90, 16'h01BB);
    send_pkt(12, mkphs(32'hC0A80001, 32'hC0A80002, 8'h06, 16'h1F90, 16'h01BB, 6'd9, 4'd0, 6'b110111), 1);
    idle(3);
    // T3: outer UDP port 2153
    build(5, 16'd2153, 3'b100, 8'h85, 1, 4'd0, 6'd9, 5, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, '0, 1);
    // T4: no GTP flags, short packet cut by next sop
    build(5, 16'd2152, 3'b000, 8'h00, 0, 4'd0, 6'd0, 5, 8'd17, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'h0035, 16'h0400);
    send_pkt(7, mkphs(32'h0A0A0A0A, 32'h0B0B0B0B, 8'h11, 16'h0035, 16'h0400, 6'd0, 4'd0, 6'b101011), 1);
    // T5: outer IHL 6, container len 2, type 1, QFI 63, TCP
    build(6, 16'd2152, 3'b100, 8'h85, 2, 4'd1, 6'h3F, 5, 8'd6, 32'h01020304, 32'h05060708, 16'hAAAA, 16'h5555);
    send_pkt(12, mkphs(32'h01020304, 32'h05060708, 8'h06, 16'hAAAA, 16'h5555, 6'h3F, 4'd1, 6'b110111), 1);
    // T6: container len 0
    build(5, 16'd2152, 3'b100, 8'h85, 0, 4'd1, 6'd5, 5, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, mkphs(0, 0, 0, 0, 0, 6'd5, 4'd1, 6'b000111), 1);
    // T7: inner IHL 4
    build(5, 16'd2152, 3'b100, 8'h85, 1, 4'd0, 6'd9, 4, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, mkphs(0, 0, 0, 0, 0, 6'd9, 4'd0, 6'b000111), 1);
    // T8: inner ICMP -> no ports, still valid
    build(5, 16'd2152, 3'b100, 8'h85, 1, 4'd0, 6'd9, 5, 8'd1, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, mkphs(A1, A2, 8'h01, 0, 0, 6'd9, 4'd0, 6'b100111), 1);
    // T9: container len 255 pushes inner header past the window
    build(5, 16'd2152, 3'b100, 8'h85, 255, 4'd0, 6'd9, 5, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, mkphs(0, 0, 0, 0, 0, 6'd9, 4'd0, 6'b000111), 1);
    // T10: S flag only, 0x85 present but E=0 -> no container, 12-byte header
    build(5, 16'd2152, 3'b010, 8'h85, 1, 4'd0, 6'd9, 5, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(12, mkphs(A1, A2, 8'h11, 16'h04D2, 16'h0050, 6'd0, 4'd0, 6'b101011), 1);
    idle(5);
    // Reset mid-packet: packet aborted, phs cleared, no update afterwards
    build(5, 16'd2152, 3'b100, 8'h85, 1, 4'd0, 6'd9, 5, 8'd17, A1, A2, 16'd1234, 16'd80);
    send_pkt(5, '0, 0);
    @(posedge clk); #1 rst_n = 0; sop = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(15);
    send_pkt(12, mkphs(A1, A2, 8'h11, 16'h04D2, 16'h0050, 6'd9, 4'd0, 6'b101111), 1);
    idle(6);
    total++;
    if (q.size() != 0 || pend_v) begin
      bad++;
      $display("FAIL drain left=%0d pend=%0d required=0", q.size(), pend_v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
